// File: rtl/core.sv
// Single-cycle RV32I core: fetch from an embedded 1K-word ROM, execute, and
// retire one instruction per clock into the register file and a 1K-word RAM.

module core_rom (
   input  logic [9:0]  idx,
   output logic [31:0] rdata
);
   logic [31:0] mem [0:1023];

   assign rdata = mem[idx];
endmodule

module core_ram (
   input  logic        clock,
   input  logic [9:0]  idx,
   output logic [31:0] rdata,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] wdata
);
   logic [31:0] mem [0:1023];

   assign rdata = mem[idx];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end
endmodule

module core (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_in_start,
   output logic [31:0] io_out_state_intRegState_regState_0,
   output logic [31:0] io_out_state_intRegState_regState_1,
   output logic [31:0] io_out_state_intRegState_regState_2,
   output logic [31:0] io_out_state_intRegState_regState_3,
   output logic [31:0] io_out_state_intRegState_regState_4,
   output logic [31:0] io_out_state_intRegState_regState_5,
   output logic [31:0] io_out_state_intRegState_regState_6,
   output logic [31:0] io_out_state_intRegState_regState_7,
   output logic [31:0] io_out_state_intRegState_regState_8,
   output logic [31:0] io_out_state_intRegState_regState_9,
   output logic [31:0] io_out_state_intRegState_regState_10,
   output logic [31:0] io_out_state_intRegState_regState_11,
   output logic [31:0] io_out_state_intRegState_regState_12,
   output logic [31:0] io_out_state_intRegState_regState_13,
   output logic [31:0] io_out_state_intRegState_regState_14,
   output logic [31:0] io_out_state_intRegState_regState_15,
   output logic [31:0] io_out_state_intRegState_regState_16,
   output logic [31:0] io_out_state_intRegState_regState_17,
   output logic [31:0] io_out_state_intRegState_regState_18,
   output logic [31:0] io_out_state_intRegState_regState_19,
   output logic [31:0] io_out_state_intRegState_regState_20,
   output logic [31:0] io_out_state_intRegState_regState_21,
   output logic [31:0] io_out_state_intRegState_regState_22,
   output logic [31:0] io_out_state_intRegState_regState_23,
   output logic [31:0] io_out_state_intRegState_regState_24,
   output logic [31:0] io_out_state_intRegState_regState_25,
   output logic [31:0] io_out_state_intRegState_regState_26,
   output logic [31:0] io_out_state_intRegState_regState_27,
   output logic [31:0] io_out_state_intRegState_regState_28,
   output logic [31:0] io_out_state_intRegState_regState_29,
   output logic [31:0] io_out_state_intRegState_regState_30,
   output logic [31:0] io_out_state_intRegState_regState_31,
   output logic        io_out_state_instState_commit,
   output logic [31:0] io_out_state_instState_pc,
   output logic [31:0] io_out_state_instState_inst
);
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   logic        running_q, running_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];
   logic        commit_q, commit_d;
   logic [31:0] commit_pc_q, commit_pc_d;
   logic [31:0] commit_inst_q, commit_inst_d;

   logic [31:0] inst, ram_rdata;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, pc_plus4;
   logic [11:0] mem_addr;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] next_pc, wb_data, st_data;
   logic        wb_en, st_en, take;
   logic [3:0]  st_be;

   core_rom rom (.idx(pc_q[11:2]), .rdata(inst));

   core_ram ram (
      .clock (clock),
      .idx   (mem_addr[11:2]),
      .rdata (ram_rdata),
      .we    (running_q & st_en & ~reset),
      .be    (st_be),
      .wdata (st_data)
   );

   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign funct3 = inst[14:12];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];
   assign funct7 = inst[31:25];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'h000};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   assign rs1_val  = rf_q[rs1];
   assign rs2_val  = rf_q[rs2];
   assign pc_plus4 = pc_q + 32'd4;

   // Only the low 12 address bits reach the RAM, so the adder stays 12 bits wide.
   assign mem_addr = rs1_val[11:0] +
                     ((opcode == OP_STORE) ? {inst[31:25], inst[11:7]} : inst[31:20]);

   always_comb begin
      ld_byte = 8'h00;
      case (mem_addr[1:0])
         2'd0: ld_byte = ram_rdata[7:0];
         2'd1: ld_byte = ram_rdata[15:8];
         2'd2: ld_byte = ram_rdata[23:16];
         2'd3: ld_byte = ram_rdata[31:24];
         default: ld_byte = 8'h00;
      endcase
      ld_half = mem_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
   end

   always_comb begin
      next_pc = pc_plus4;
      wb_en   = 1'b0;
      wb_data = 32'h0;
      st_en   = 1'b0;
      st_be   = 4'b0000;
      st_data = rs2_val;
      take    = 1'b0;
      case (opcode)
         OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
         OP_AUIPC: begin wb_en = 1'b1; wb_data = pc_q + imm_u; end
         OP_JAL: begin
            wb_en = 1'b1; wb_data = pc_plus4; next_pc = pc_q + imm_j;
         end
         OP_JALR: begin
            if (funct3 == 3'd0) begin
               wb_en = 1'b1; wb_data = pc_plus4;
               next_pc = (rs1_val + imm_i) & ~32'd1;
            end
         end
         OP_BRANCH: begin
            case (funct3)
               3'd0: take = (rs1_val == rs2_val);
               3'd1: take = (rs1_val != rs2_val);
               3'd4: take = ($signed(rs1_val) <  $signed(rs2_val));
               3'd5: take = ($signed(rs1_val) >= $signed(rs2_val));
               3'd6: take = (rs1_val <  rs2_val);
               3'd7: take = (rs1_val >= rs2_val);
               default: take = 1'b0;
            endcase
            if (take) next_pc = pc_q + imm_b;
         end
         OP_LOAD: begin
            case (funct3)
               3'd0: begin wb_en = 1'b1; wb_data = {{24{ld_byte[7]}}, ld_byte}; end
               3'd1: begin wb_en = 1'b1; wb_data = {{16{ld_half[15]}}, ld_half}; end
               3'd2: begin wb_en = 1'b1; wb_data = ram_rdata; end
               3'd4: begin wb_en = 1'b1; wb_data = {24'h0, ld_byte}; end
               3'd5: begin wb_en = 1'b1; wb_data = {16'h0, ld_half}; end
               default: wb_en = 1'b0;
            endcase
         end
         OP_STORE: begin
            case (funct3)
               3'd0: begin
                  st_en = 1'b1; st_data = {4{rs2_val[7:0]}};
                  st_be = 4'b0001 << mem_addr[1:0];
               end
               3'd1: begin
                  st_en = 1'b1; st_data = {2{rs2_val[15:0]}};
                  st_be = mem_addr[1] ? 4'b1100 : 4'b0011;
               end
               3'd2: begin st_en = 1'b1; st_be = 4'b1111; end
               default: st_en = 1'b0;
            endcase
         end
         OP_IMM: begin
            wb_en = 1'b1;
            case (funct3)
               3'd0: wb_data = rs1_val + imm_i;
               3'd2: wb_data = {31'h0, $signed(rs1_val) < $signed(imm_i)};
               3'd3: wb_data = {31'h0, rs1_val < imm_i};
               3'd4: wb_data = rs1_val ^ imm_i;
               3'd6: wb_data = rs1_val | imm_i;
               3'd7: wb_data = rs1_val & imm_i;
               3'd1: begin
                  wb_en   = (funct7 == 7'h00);
                  wb_data = rs1_val << rs2;
               end
               3'd5: begin
                  wb_en   = (funct7 == 7'h00) || (funct7 == 7'h20);
                  wb_data = funct7[5] ? 32'($signed(rs1_val) >>> rs2) : rs1_val >> rs2;
               end
               default: wb_en = 1'b0;
            endcase
         end
         OP_REG: begin
            if (funct7 == 7'h00) begin
               wb_en = 1'b1;
               case (funct3)
                  3'd0: wb_data = rs1_val + rs2_val;
                  3'd1: wb_data = rs1_val << rs2_val[4:0];
                  3'd2: wb_data = {31'h0, $signed(rs1_val) < $signed(rs2_val)};
                  3'd3: wb_data = {31'h0, rs1_val < rs2_val};
                  3'd4: wb_data = rs1_val ^ rs2_val;
                  3'd5: wb_data = rs1_val >> rs2_val[4:0];
                  3'd6: wb_data = rs1_val | rs2_val;
                  3'd7: wb_data = rs1_val & rs2_val;
                  default: wb_data = 32'h0;
               endcase
            end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
               wb_en = 1'b1; wb_data = rs1_val - rs2_val;
            end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
               wb_en = 1'b1; wb_data = 32'($signed(rs1_val) >>> rs2_val[4:0]);
            end
         end
         default: wb_en = 1'b0;
      endcase
   end

   // Nothing architectural moves until the sticky run flag is set.
   always_comb begin
      running_d = running_q | io_in_start;
      pc_d      = running_q ? next_pc : pc_q;
      rf_d      = rf_q;
      if (running_q && wb_en) rf_d[rd] = wb_data;
      rf_d[0]       = 32'h0;
      commit_d      = running_q;
      commit_pc_d   = running_q ? pc_q : 32'h0;
      commit_inst_d = running_q ? inst : 32'h0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         running_q     <= 1'b0;
         pc_q          <= 32'h0;
         rf_q          <= '{default: 32'h0};
         commit_q      <= 1'b0;
         commit_pc_q   <= 32'h0;
         commit_inst_q <= 32'h0;
      end else begin
         running_q     <= running_d;
         pc_q          <= pc_d;
         rf_q          <= rf_d;
         commit_q      <= commit_d;
         commit_pc_q   <= commit_pc_d;
         commit_inst_q <= commit_inst_d;
      end
   end

   assign io_out_state_instState_commit = commit_q;
   assign io_out_state_instState_pc     = commit_pc_q;
   assign io_out_state_instState_inst   = commit_inst_q;

   assign io_out_state_intRegState_regState_0  = rf_q[0];
   assign io_out_state_intRegState_regState_1  = rf_q[1];
   assign io_out_state_intRegState_regState_2  = rf_q[2];
   assign io_out_state_intRegState_regState_3  = rf_q[3];
   assign io_out_state_intRegState_regState_4  = rf_q[4];
   assign io_out_state_intRegState_regState_5  = rf_q[5];
   assign io_out_state_intRegState_regState_6  = rf_q[6];
   assign io_out_state_intRegState_regState_7  = rf_q[7];
   assign io_out_state_intRegState_regState_8  = rf_q[8];
   assign io_out_state_intRegState_regState_9  = rf_q[9];
   assign io_out_state_intRegState_regState_10 = rf_q[10];
   assign io_out_state_intRegState_regState_11 = rf_q[11];
   assign io_out_state_intRegState_regState_12 = rf_q[12];
   assign io_out_state_intRegState_regState_13 = rf_q[13];
   assign io_out_state_intRegState_regState_14 = rf_q[14];
   assign io_out_state_intRegState_regState_15 = rf_q[15];
   assign io_out_state_intRegState_regState_16 = rf_q[16];
   assign io_out_state_intRegState_regState_17 = rf_q[17];
   assign io_out_state_intRegState_regState_18 = rf_q[18];
   assign io_out_state_intRegState_regState_19 = rf_q[19];
   assign io_out_state_intRegState_regState_20 = rf_q[20];
   assign io_out_state_intRegState_regState_21 = rf_q[21];
   assign io_out_state_intRegState_regState_22 = rf_q[22];
   assign io_out_state_intRegState_regState_23 = rf_q[23];
   assign io_out_state_intRegState_regState_24 = rf_q[24];
   assign io_out_state_intRegState_regState_25 = rf_q[25];
   assign io_out_state_intRegState_regState_26 = rf_q[26];
   assign io_out_state_intRegState_regState_27 = rf_q[27];
   assign io_out_state_intRegState_regState_28 = rf_q[28];
   assign io_out_state_intRegState_regState_29 = rf_q[29];
   assign io_out_state_intRegState_regState_30 = rf_q[30];
   assign io_out_state_intRegState_regState_31 = rf_q[31];
endmodule

// File: tb/tb_core.sv
// Directed-program bench for the single-cycle RV32I core: each task loads a
// short ROM program, runs it and checks the commit record and register file.

module tb_core;
   logic        clock;
   logic        reset;
   logic        io_in_start;
   logic [31:0] regs [32];
   logic        commit;
   logic [31:0] cpc;
   logic [31:0] cinst;
   int          n_checks;
   int          n_fail;

   core dut (
      .clock (clock), .reset (reset), .io_in_start (io_in_start),
      .io_out_state_intRegState_regState_0  (regs[0]),
      .io_out_state_intRegState_regState_1  (regs[1]),
      .io_out_state_intRegState_regState_2  (regs[2]),
      .io_out_state_intRegState_regState_3  (regs[3]),
      .io_out_state_intRegState_regState_4  (regs[4]),
      .io_out_state_intRegState_regState_5  (regs[5]),
      .io_out_state_intRegState_regState_6  (regs[6]),
      .io_out_state_intRegState_regState_7  (regs[7]),
      .io_out_state_intRegState_regState_8  (regs[8]),
      .io_out_state_intRegState_regState_9  (regs[9]),
      .io_out_state_intRegState_regState_10 (regs[10]),
      .io_out_state_intRegState_regState_11 (regs[11]),
      .io_out_state_intRegState_regState_12 (regs[12]),
      .io_out_state_intRegState_regState_13 (regs[13]),
      .io_out_state_intRegState_regState_14 (regs[14]),
      .io_out_state_intRegState_regState_15 (regs[15]),
      .io_out_state_intRegState_regState_16 (regs[16]),
      .io_out_state_intRegState_regState_17 (regs[17]),
      .io_out_state_intRegState_regState_18 (regs[18]),
      .io_out_state_intRegState_regState_19 (regs[19]),
      .io_out_state_intRegState_regState_20 (regs[20]),
      .io_out_state_intRegState_regState_21 (regs[21]),
      .io_out_state_intRegState_regState_22 (regs[22]),
      .io_out_state_intRegState_regState_23 (regs[23]),
      .io_out_state_intRegState_regState_24 (regs[24]),
      .io_out_state_intRegState_regState_25 (regs[25]),
      .io_out_state_intRegState_regState_26 (regs[26]),
      .io_out_state_intRegState_regState_27 (regs[27]),
      .io_out_state_intRegState_regState_28 (regs[28]),
      .io_out_state_intRegState_regState_29 (regs[29]),
      .io_out_state_intRegState_regState_30 (regs[30]),
      .io_out_state_intRegState_regState_31 (regs[31]),
      .io_out_state_instState_commit (commit),
      .io_out_state_instState_pc     (cpc),
      .io_out_state_instState_inst   (cinst)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   localparam logic [31:0] NOP = 32'h00000013;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) dut.rom.mem[i] = NOP;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      io_in_start = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic start_pulse();
      io_in_start = 1'b1;
      step();
      io_in_start = 1'b0;
   endtask

   task automatic test_reset();
      int bad_commit;
      clear_rom();
      dut.rom.mem[0] = 32'h00500093;
      apply_reset();
      n_checks++; if (commit !== 1'b0) begin n_fail++; $display("FAIL reset_commit got=%0h exp=0", commit); end
      n_checks++; if (cpc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=00000000", cpc); end
      n_checks++; if (cinst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=00000000", cinst); end
      n_checks++; if (regs[1] !== 32'h0) begin n_fail++; $display("FAIL reset_x1 got=%h exp=00000000", regs[1]); end
      bad_commit = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (commit !== 1'b0 || regs[1] !== 32'h0) bad_commit++;
      end
      n_checks++; if (bad_commit !== 0) begin n_fail++; $display("FAIL idle_before_start got=%0d exp=0", bad_commit); end
      start_pulse();
      n_checks++; if (commit !== 1'b0) begin n_fail++; $display("FAIL start_edge_commit got=%0h exp=0", commit); end
      step();
      n_checks++; if (commit !== 1'b1) begin n_fail++; $display("FAIL first_commit got=%0h exp=1", commit); end
      n_checks++; if (cpc !== 32'h0) begin n_fail++; $display("FAIL first_pc got=%h exp=00000000", cpc); end
      n_checks++; if (cinst !== 32'h00500093) begin n_fail++; $display("FAIL first_inst got=%h exp=00500093", cinst); end
      n_checks++; if (regs[1] !== 32'd5) begin n_fail++; $display("FAIL first_x1 got=%h exp=00000005", regs[1]); end
   endtask

   task automatic test_lui_addi();
      clear_rom();
      dut.rom.mem[0] = {20'h12345, 5'd2, 7'h37};
      dut.rom.mem[1] = enc_i(12'h678, 5'd2, 3'd0, 5'd2, 7'h13);
      dut.rom.mem[2] = enc_i(12'h001, 5'd0, 3'd0, 5'd0, 7'h13);
      apply_reset();
      start_pulse();
      step();
      n_checks++; if (cpc !== 32'h0) begin n_fail++; $display("FAIL lui_pc got=%h exp=00000000", cpc); end
      n_checks++; if (regs[2] !== 32'h12345000) begin n_fail++; $display("FAIL lui_x2 got=%h exp=12345000", regs[2]); end
      step();
      n_checks++; if (cpc !== 32'h4) begin n_fail++; $display("FAIL addi_pc got=%h exp=00000004", cpc); end
      n_checks++; if (regs[2] !== 32'h12345678) begin n_fail++; $display("FAIL addi_x2 got=%h exp=12345678", regs[2]); end
      step();
      n_checks++; if (cpc !== 32'h8 || commit !== 1'b1) begin n_fail++; $display("FAIL x0_write_pc got=%h/%0h exp=00000008/1", cpc, commit); end
      n_checks++; if (regs[0] !== 32'h0) begin n_fail++; $display("FAIL x0_stays_zero got=%h exp=00000000", regs[0]); end
   endtask

   task automatic test_shifts();
      clear_rom();
      dut.rom.mem[0] = enc_i(12'hfff, 5'd0, 3'd0, 5'd3, 7'h13);
      dut.rom.mem[1] = enc_i(12'h01c, 5'd3, 3'd5, 5'd4, 7'h13);
      dut.rom.mem[2] = enc_i(12'h41c, 5'd3, 3'd5, 5'd5, 7'h13);
      dut.rom.mem[3] = enc_r(7'h00, 5'd3, 5'd0, 3'd3, 5'd6);
      dut.rom.mem[4] = enc_r(7'h00, 5'd0, 5'd3, 3'd2, 5'd8);
      dut.rom.mem[5] = enc_r(7'h20, 5'd3, 5'd0, 3'd0, 5'd9);
      apply_reset();
      start_pulse();
      for (int i = 0; i < 6; i++) step();
      n_checks++; if (regs[3] !== 32'hffffffff) begin n_fail++; $display("FAIL addi_neg got=%h exp=ffffffff", regs[3]); end
      n_checks++; if (regs[4] !== 32'h0000000f) begin n_fail++; $display("FAIL srli got=%h exp=0000000f", regs[4]); end
      n_checks++; if (regs[5] !== 32'hffffffff) begin n_fail++; $display("FAIL srai got=%h exp=ffffffff", regs[5]); end
      n_checks++; if (regs[6] !== 32'h1) begin n_fail++; $display("FAIL sltu got=%h exp=00000001", regs[6]); end
      n_checks++; if (regs[8] !== 32'h1) begin n_fail++; $display("FAIL slt got=%h exp=00000001", regs[8]); end
      n_checks++; if (regs[9] !== 32'h1) begin n_fail++; $display("FAIL sub got=%h exp=00000001", regs[9]); end
      n_checks++; if (cpc !== 32'h14) begin n_fail++; $display("FAIL shifts_last_pc got=%h exp=00000014", cpc); end
   endtask

   task automatic test_memory();
      clear_rom();
      dut.rom.mem[0]  = enc_i(12'h080, 5'd0, 3'd0, 5'd7, 7'h13);
      dut.rom.mem[1]  = {20'hdeadc, 5'd10, 7'h37};
      dut.rom.mem[2]  = enc_i(12'heef, 5'd10, 3'd0, 5'd10, 7'h13);
      dut.rom.mem[3]  = enc_s(12'h000, 5'd10, 5'd7, 3'd2);
      dut.rom.mem[4]  = enc_i(12'h011, 5'd0, 3'd0, 5'd11, 7'h13);
      dut.rom.mem[5]  = enc_s(12'h001, 5'd11, 5'd7, 3'd0);
      dut.rom.mem[6]  = enc_i(12'h000, 5'd7, 3'd2, 5'd12, 7'h03);
      dut.rom.mem[7]  = enc_i(12'h003, 5'd7, 3'd0, 5'd13, 7'h03);
      dut.rom.mem[8]  = enc_i(12'h001, 5'd7, 3'd4, 5'd14, 7'h03);
      dut.rom.mem[9]  = enc_i(12'h002, 5'd7, 3'd1, 5'd15, 7'h03);
      dut.rom.mem[10] = enc_i(12'h002, 5'd7, 3'd5, 5'd16, 7'h03);
      apply_reset();
      start_pulse();
      for (int i = 0; i < 4; i++) step();
      n_checks++; if (dut.ram.mem[32] !== 32'hdeadbeef) begin n_fail++; $display("FAIL sw_word got=%h exp=deadbeef", dut.ram.mem[32]); end
      step();
      step();
      n_checks++; if (dut.ram.mem[32] !== 32'hdead11ef) begin n_fail++; $display("FAIL sb_word got=%h exp=dead11ef", dut.ram.mem[32]); end
      for (int i = 0; i < 5; i++) step();
      n_checks++; if (regs[12] !== 32'hdead11ef) begin n_fail++; $display("FAIL lw got=%h exp=dead11ef", regs[12]); end
      n_checks++; if (regs[13] !== 32'hffffffde) begin n_fail++; $display("FAIL lb got=%h exp=ffffffde", regs[13]); end
      n_checks++; if (regs[14] !== 32'h00000011) begin n_fail++; $display("FAIL lbu got=%h exp=00000011", regs[14]); end
      n_checks++; if (regs[15] !== 32'hffffdead) begin n_fail++; $display("FAIL lh got=%h exp=ffffdead", regs[15]); end
      n_checks++; if (regs[16] !== 32'h0000dead) begin n_fail++; $display("FAIL lhu got=%h exp=0000dead", regs[16]); end
   endtask

   task automatic test_branch_jump();
      logic [31:0] exp_pc [13];
      exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0c, 32'h04, 32'h08, 32'h0c,
                 32'h10, 32'h14, 32'h1c, 32'h20, 32'h30, 32'h40};
      clear_rom();
      dut.rom.mem[0]  = enc_i(12'h001, 5'd0, 3'd0, 5'd22, 7'h13);
      dut.rom.mem[1]  = enc_i(12'h001, 5'd20, 3'd0, 5'd20, 7'h13);
      dut.rom.mem[3]  = enc_b(13'h1ff8, 5'd22, 5'd20, 3'd0);
      dut.rom.mem[4]  = enc_b(13'h0008, 5'd20, 5'd20, 3'd1);
      dut.rom.mem[5]  = enc_b(13'h0008, 5'd22, 5'd0, 3'd6);
      dut.rom.mem[8]  = enc_j(21'h00010, 5'd1);
      dut.rom.mem[12] = enc_i(12'h041, 5'd0, 3'd0, 5'd24, 7'h67);
      dut.rom.mem[16] = enc_i(12'h007, 5'd0, 3'd0, 5'd25, 7'h13);
      apply_reset();
      start_pulse();
      for (int i = 0; i < 13; i++) begin
         step();
         n_checks++; if (cpc !== exp_pc[i] || commit !== 1'b1) begin n_fail++; $display("FAIL flow_pc[%0d] got=%h/%0h exp=%h/1", i, cpc, commit, exp_pc[i]); end
         if (i == 10) begin
            n_checks++; if (regs[1] !== 32'h24) begin n_fail++; $display("FAIL jal_link got=%h exp=00000024", regs[1]); end
         end
         if (i == 11) begin
            n_checks++; if (regs[24] !== 32'h34) begin n_fail++; $display("FAIL jalr_link got=%h exp=00000034", regs[24]); end
         end
      end
      n_checks++; if (regs[25] !== 32'd7) begin n_fail++; $display("FAIL jalr_target_x25 got=%h exp=00000007", regs[25]); end
      n_checks++; if (regs[20] !== 32'd2) begin n_fail++; $display("FAIL loop_count got=%h exp=00000002", regs[20]); end
   endtask

   task automatic test_reset_mid_run();
      int bad_commit;
      clear_rom();
      dut.rom.mem[0] = enc_i(12'h005, 5'd0, 3'd0, 5'd1, 7'h13);
      dut.rom.mem[1] = enc_i(12'h006, 5'd0, 3'd0, 5'd2, 7'h13);
      dut.rom.mem[2] = enc_j(21'h0, 5'd0);
      apply_reset();
      start_pulse();
      step();
      n_checks++; if (regs[1] !== 32'd5) begin n_fail++; $display("FAIL pre_reset_x1 got=%h exp=00000005", regs[1]); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++; if (commit !== 1'b0 || cpc !== 32'h0 || cinst !== 32'h0) begin n_fail++; $display("FAIL mid_reset_commit got=%0h/%h/%h exp=0/0/0", commit, cpc, cinst); end
      n_checks++; if (regs[1] !== 32'h0) begin n_fail++; $display("FAIL mid_reset_x1 got=%h exp=00000000", regs[1]); end
      n_checks++; if (regs[2] !== 32'h0) begin n_fail++; $display("FAIL mid_reset_inflight_x2 got=%h exp=00000000", regs[2]); end
      bad_commit = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (commit !== 1'b0) bad_commit++;
      end
      n_checks++; if (bad_commit !== 0) begin n_fail++; $display("FAIL run_needs_restart got=%0d exp=0", bad_commit); end
      start_pulse();
      step();
      n_checks++; if (commit !== 1'b1 || cpc !== 32'h0) begin n_fail++; $display("FAIL restart_pc got=%0h/%h exp=1/00000000", commit, cpc); end
      n_checks++; if (regs[1] !== 32'd5) begin n_fail++; $display("FAIL restart_x1 got=%h exp=00000005", regs[1]); end
      n_checks++; if (dut.ram.mem[32] !== 32'hdead11ef) begin n_fail++; $display("FAIL ram_retained got=%h exp=dead11ef", dut.ram.mem[32]); end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      reset = 1'b1;
      io_in_start = 1'b0;
      test_reset();
      test_lui_addi();
      test_shifts();
      test_memory();
      test_branch_jump();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/core.md
# core

Single-cycle RV32I integer core with an embedded instruction ROM and data RAM. It is the top computational block under the simulation wrapper: it fetches, executes and retires one instruction per clock once started. It exports the full architectural register file and a per-instruction commit record for lock-step comparison against a reference model.

## Interface
- Parameters: none. ROM and RAM are fixed at 1024 × 32-bit words each.
- ROM instance is named `rom` with word array `mem[0:1023]`. RAM instance is named `ram` with word array `mem[0:1023]`.
- Both arrays are loadable by hierarchical `$readmemh` and have no reset.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `io_in_start`  in  1  run enable; sampled high sets an internal sticky `running` flag.
- `io_out_state_intRegState_regState_0` … `_31`  out  32 each  live register-file contents x0..x31; x0 is always 0.
- `io_out_state_instState_commit`  out  1  high for one cycle per retired instruction.
- `io_out_state_instState_pc`  out  32  PC of the retired instruction.
- `io_out_state_instState_inst`  out  32  encoding of the retired instruction.

## Operation
- Fetch: `inst = rom.mem[pc[11:2]]`, combinational read. Addresses alias modulo 4 KiB.
- Decode and execute the full RV32I base set:
  - LUI, AUIPC, JAL, JALR (target &~1)
  - BEQ, BNE, BLT, BGE, BLTU, BGEU
  - LB, LH, LW, LBU, LHU; SB, SH, SW
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA
- FENCE, ECALL, EBREAK and any unrecognised encoding execute as NOPs: no register or memory write, PC+4. They still commit.
- Arithmetic is 32-bit two's complement, wrapping. Shift amount is bits [4:0]. SLT compares signed, SLTU compares unsigned.
- Branch and JAL targets are pc + sign-extended immediate. Misaligned targets are not trapped; low bits are ignored by the fetch index.
- Data memory addressing:
  - Word index is `addr[11:2]`; byte lane is `addr[1:0]`. Read is combinational.
  - Loads sign- or zero-extend the selected byte or halfword.
  - Stores write only the addressed lanes on the clock edge; SB/SH update only their byte/halfword.
  - Halfword uses lane `addr[1]`; word ignores `addr[1:0]`. No misalignment trap.
- Register file: writes to x0 are discarded. Reads are combinational and see the pre-edge value.
- `running` flag: cleared by reset, set on any edge where `io_in_start`=1, then stays set until the next reset.
- While not running: no PC, register, RAM or commit state changes, and commit=0.

## Timing
- Reset values:
  - pc = 0x0000_0000, running = 0.
  - x1..x31 = 0.
  - commit = 0, commit pc = 0, commit inst = 0.
  - RAM and ROM contents are unaffected.
- Start: on the edge sampling start=1, `running` is set. The first instruction (pc 0) executes in the following cycle.
- Retire, on each edge while running:
  - pc ← next PC.
  - Register file and RAM write-back occur.
  - commit ← 1, commit pc ← pc of the executed instruction, commit inst ← inst.
- Observation: in the cycle after that edge, regState already shows the retired instruction's result alongside commit=1 and its pc/inst.
- Latency: 1 instruction per cycle, with no stalls and no bubbles.
- Commit outputs stay 0 for any cycle in which nothing retired.
- Reset asserted mid-run takes priority over everything on that edge:
  - State returns to reset values; no write-back of the in-flight instruction.
  - `running` clears, so start is required again.

## Test plan
1. Reset, then start pulse, with ROM[0] = `addi x1,x0,5` (0x00500093).
   - Required: first commit shows pc=0, inst=0x00500093, regState_1=5. Before start, commit stays 0 indefinitely.
2. `lui x2,0x12345`, `addi x2,x2,0x678`, `addi x0,x0,1`.
   - Required: x2=0x12345000, then x2=0x12345678; x0 stays 0; three commits with pcs 0, 4, 8.
3. `addi x3,x0,-1`, `srli x4,x3,28`, `srai x5,x3,28`, `sltu x6,x0,x3`.
   - Required: x4=0xF, x5=0xFFFFFFFF, x6=1.
4. x7=0x80, store `sw` 0xDEADBEEF to 0(x7), then `sb` 0x11 to 1(x7), then `lw`, `lb`, `lbu` from 0(x7).
   - Required: word reads 0xDEAD11EF; `lb` of byte 3 gives 0xFFFFFFDE; `lbu` of byte 1 gives 0x11.
5. Branches and jumps:
   - `beq` taken back 8 bytes: next commit pc = branch pc − 8.
   - Not-taken `bne`: next commit pc = pc + 4.
   - `jal x1,+16` at pc 0x20: x1=0x24, next pc 0x30.
   - `jalr` to an odd address: bit 0 cleared.
6. Assert reset mid-program.
   - Required: outputs and registers return to 0, pc restarts at 0 after a new start pulse, and RAM retains its previously stored values.
